race_ctrl: RTL and testbench

//  Race sequencer that sits directly upstream of the BCD race-time counter.

---
 rtl/race_ctrl_if.sv | 30 +++
 rtl/race_ctrl.sv | 131 +++++++++++++
 tb/tb_race_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/race_ctrl_if.sv
// Signal bundle between the race sequencer and its board-side neighbours:
// raw buttons, 1 Hz tick and BCD time in; counter controls and results out.
interface race_ctrl_if;
    logic       start_btn;
    logic       p1_btn;
    logic       p2_btn;
    logic       tick;
    logic [3:0] time_ones;
    logic [3:0] time_tens;
    logic       count_enable;
    logic       count_clear;
    logic [3:0] countdown_val;
    logic [1:0] state;
    logic [1:0] winner;
    logic [3:0] result_ones;
    logic [3:0] result_tens;
    logic       result_valid;

    modport master (
        output start_btn, p1_btn, p2_btn, tick, time_ones, time_tens,
        input  count_enable, count_clear, countdown_val, state,
        input  winner, result_ones, result_tens, result_valid
    );

    modport slave (
        input  start_btn, p1_btn, p2_btn, tick, time_ones, time_tens,
        output count_enable, count_clear, countdown_val, state,
        output winner, result_ones, result_tens, result_valid
    );
endinterface

// File: rtl/race_ctrl.sv
// Race sequencer: countdown, race gating of the BCD time counter,
// finish detection and latching of winner and final time.
module race_ctrl #(
    parameter logic [3:0] COUNTDOWN_START = 4'd3
) (
    input logic        clock,
    input logic        reset,
    race_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        RUNNING   = 2'd2,
        FINISHED  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] start_sync, p1_sync, p2_sync;
    logic       start_edge, p1_edge, p2_edge;
    logic       any_player, timeout;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] winner_q, winner_d;
    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;

    // bit0/bit1 form the synchroniser, bit2 delays for edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_sync <= 3'b000;
            p1_sync    <= 3'b000;
            p2_sync    <= 3'b000;
        end else begin
            start_sync <= {start_sync[1:0], bus.start_btn};
            p1_sync    <= {p1_sync[1:0], bus.p1_btn};
            p2_sync    <= {p2_sync[1:0], bus.p2_btn};
        end
    end

    assign start_edge = start_sync[1] & ~start_sync[2];
    assign p1_edge    = p1_sync[1] & ~p1_sync[2];
    assign p2_edge    = p2_sync[1] & ~p2_sync[2];
    assign any_player = p1_edge | p2_edge;
    assign timeout    = (bus.time_tens == 4'd9) && (bus.time_ones == 4'd9);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            winner_q <= 2'b00;
            ones_q   <= 4'd0;
            tens_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            winner_q <= winner_d;
            ones_q   <= ones_d;
            tens_q   <= tens_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        winner_d = winner_q;
        ones_d   = ones_q;
        tens_d   = tens_q;
        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = COUNTDOWN;
                    cnt_d   = COUNTDOWN_START;
                end
            end
            COUNTDOWN: begin
                if (start_edge) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (any_player) begin
                    // false start: the other player takes the win
                    state_d  = FINISHED;
                    cnt_d    = 4'd0;
                    winner_d = {p1_edge & ~p2_edge, p2_edge & ~p1_edge};
                    ones_d   = 4'd0;
                    tens_d   = 4'd0;
                end else if (bus.tick) begin
                    if (cnt_q == 4'd1) begin
                        state_d = RUNNING;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            RUNNING: begin
                if (start_edge) begin
                    state_d = IDLE;
                end else if (any_player) begin
                    state_d  = FINISHED;
                    winner_d = {p2_edge, p1_edge};
                    ones_d   = bus.time_ones;
                    tens_d   = bus.time_tens;
                end else if (timeout) begin
                    state_d  = FINISHED;
                    winner_d = 2'b00;
                    ones_d   = 4'd9;
                    tens_d   = 4'd9;
                end
            end
            FINISHED: begin
                if (start_edge) begin
                    state_d  = IDLE;
                    winner_d = 2'b00;
                    ones_d   = 4'd0;
                    tens_d   = 4'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.count_enable  = (state_q == RUNNING);
        bus.count_clear   = (state_q == IDLE);
        bus.result_valid  = (state_q == FINISHED);
        bus.state         = state_q;
        bus.countdown_val = cnt_q;
        bus.winner        = winner_q;
        bus.result_ones   = ones_q;
        bus.result_tens   = tens_q;
    end
endmodule

// File: tb/tb_race_ctrl.sv
// Self-checking bench for race_ctrl: direct state checks plus a
// scoreboard of expected finish records popped when result_valid rises.
module tb_race_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;
    logic valid_prev = 1'b0;
    logic [11:0] sb_q[$];

    race_ctrl_if bus();

    race_ctrl #(.COUNTDOWN_START(4'd3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // mask = {start, p1, p2}; hold keeps the buttons down after the edge
    task automatic press(input logic [2:0] mask, input int hold);
        repeat (4) @(posedge clock);
        #1 {bus.start_btn, bus.p1_btn, bus.p2_btn} = mask;
        repeat (3 + hold) @(posedge clock);
        #1 {bus.start_btn, bus.p1_btn, bus.p2_btn} = 3'b000;
    endtask

    task automatic tick_pulse();
        @(posedge clock);
        #1 bus.tick = 1'b1;
        @(posedge clock);
        #1 bus.tick = 1'b0;
    endtask

    // start edge and tick reach the FSM on the same clock edge
    task automatic abort_with_tick();
        repeat (4) @(posedge clock);
        #1 bus.start_btn = 1'b1;
        repeat (2) @(posedge clock);
        #1 bus.tick = 1'b1;
        @(posedge clock);
        #1 begin
            bus.start_btn = 1'b0;
            bus.tick = 1'b0;
        end
    endtask

    task automatic set_time(input logic [3:0] tens, input logic [3:0] ones);
        bus.time_tens = tens;
        bus.time_ones = ones;
    endtask

    task automatic to_running();
        press(3'b100, 0);
        repeat (3) tick_pulse();
        @(negedge clock);
        check("running", 32'(bus.state), 32'd2);
    endtask

    always @(negedge clock) begin
        if (bus.result_valid && !valid_prev) begin
            check("sb_pending", 32'(sb_q.size()), 32'd1);
            if (sb_q.size() != 0)
                check("sb_result",
                      32'({bus.state, bus.winner, bus.result_tens, bus.result_ones}),
                      32'(sb_q.pop_front()));
        end
        valid_prev = bus.result_valid;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        {bus.start_btn, bus.p1_btn, bus.p2_btn, bus.tick} = 4'b0000;
        set_time(4'd0, 4'd0);
        repeat (2) @(negedge clock);
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_clear", 32'(bus.count_clear), 32'd1);
        check("rst_enable", 32'(bus.count_enable), 32'd0);
        check("rst_winner", 32'(bus.winner), 32'd0);
        check("rst_valid", 32'(bus.result_valid), 32'd0);
        check("rst_cd", 32'(bus.countdown_val), 32'd0);
        reset = 1'b0;

        press(3'b011, 0);
        @(negedge clock);
        check("idle_ignore", 32'(bus.state), 32'd0);

        press(3'b100, 6);
        @(negedge clock);
        check("cd_state", 32'(bus.state), 32'd1);
        check("cd_3", 32'(bus.countdown_val), 32'd3);
        tick_pulse();
        @(negedge clock);
        check("cd_2", 32'(bus.countdown_val), 32'd2);
        tick_pulse();
        @(negedge clock);
        check("cd_1", 32'(bus.countdown_val), 32'd1);
        check("cd_enable", 32'(bus.count_enable), 32'd0);
        tick_pulse();
        @(negedge clock);
        check("go_state", 32'(bus.state), 32'd2);
        check("go_cd", 32'(bus.countdown_val), 32'd0);
        check("go_enable", 32'(bus.count_enable), 32'd1);
        check("go_clear", 32'(bus.count_clear), 32'd0);

        set_time(4'd2, 4'd1);
        sb_q.push_back({2'd3, 2'b10, 4'd2, 4'd1});
        press(3'b001, 0);
        @(negedge clock);
        check("p2_state", 32'(bus.state), 32'd3);
        check("p2_enable", 32'(bus.count_enable), 32'd0);
        check("p2_valid", 32'(bus.result_valid), 32'd1);
        check("p2_result", 32'({bus.result_tens, bus.result_ones}), 32'h21);

        set_time(4'd3, 4'd5);
        press(3'b010, 0);
        @(negedge clock);
        check("fin_ignore", 32'({bus.state, bus.winner, bus.result_tens, bus.result_ones}),
              32'({2'd3, 2'b10, 4'd2, 4'd1}));

        press(3'b100, 0);
        @(negedge clock);
        check("fin_exit", 32'({bus.state, bus.winner, bus.result_tens, bus.result_ones}), 32'd0);
        check("fin_valid", 32'(bus.result_valid), 32'd0);

        set_time(4'd5, 4'd6);
        press(3'b100, 0);
        tick_pulse();
        @(negedge clock);
        check("fs_cd", 32'(bus.countdown_val), 32'd2);
        sb_q.push_back({2'd3, 2'b10, 4'd0, 4'd0});
        press(3'b010, 0);
        @(negedge clock);
        check("fs_p1", 32'(bus.winner), 32'd2);
        check("fs_cd0", 32'(bus.countdown_val), 32'd0);
        press(3'b100, 0);
        press(3'b100, 0);
        sb_q.push_back({2'd3, 2'b00, 4'd0, 4'd0});
        press(3'b011, 0);
        @(negedge clock);
        check("fs_both", 32'({bus.state, bus.winner}), 32'({2'd3, 2'b00}));
        press(3'b100, 0);
        set_time(4'd0, 4'd0);

        press(3'b100, 0);
        tick_pulse();
        abort_with_tick();
        @(negedge clock);
        check("abort_tick", 32'({bus.state, bus.countdown_val}), 32'd0);

        to_running();
        set_time(4'd4, 4'd7);
        sb_q.push_back({2'd3, 2'b11, 4'd4, 4'd7});
        press(3'b011, 0);
        @(negedge clock);
        check("tie", 32'({bus.winner, bus.result_tens, bus.result_ones}),
              32'({2'b11, 4'd4, 4'd7}));
        press(3'b100, 0);
        set_time(4'd0, 4'd0);

        to_running();
        sb_q.push_back({2'd3, 2'b00, 4'd9, 4'd9});
        @(posedge clock);
        #1 set_time(4'd9, 4'd9);
        @(posedge clock);
        @(negedge clock);
        check("timeout", 32'({bus.state, bus.winner, bus.result_tens, bus.result_ones}),
              32'({2'd3, 2'b00, 4'd9, 4'd9}));
        press(3'b100, 0);
        set_time(4'd0, 4'd0);

        to_running();
        press(3'b100, 0);
        @(negedge clock);
        check("run_abort", 32'({bus.state, bus.count_clear, bus.count_enable}),
              32'({2'd0, 1'b1, 1'b0}));

        press(3'b100, 0);
        @(negedge clock);
        check("pre_rst", 32'(bus.state), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst", 32'({bus.state, bus.countdown_val, bus.count_clear}),
              32'({2'd0, 4'd0, 1'b1}));
        @(negedge clock);
        reset = 1'b0;

        repeat (2) @(negedge clock);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
